// File: rtl/algo_mrw_refr_sched.sv
// Refresh scheduler for the sub-banks of the multiport algorithmic memories:
// credit accounting, conflict-aware deferral, forced refresh with stall, init sweep.
module algo_mrw_refr_sched #(
  parameter int NUMPT    = 2,
  parameter int NUMRBNK  = 4,
  parameter int BITRBNK  = 2,
  parameter int REFFRHF  = 0,
  parameter int MAXCRED  = 7,
  parameter int BITCRED  = 3,
  parameter int MAXDEFER = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       refr,
  input  logic [NUMPT-1:0]           acc_vld,
  input  logic [NUMPT*BITRBNK-1:0]   acc_bank,
  output logic                       ready,
  output logic                       refrB,
  output logic [BITRBNK-1:0]         bankB,
  output logic                       stall,
  output logic [BITRBNK-1:0]         stall_bank,
  output logic [BITCRED-1:0]         cred,
  output logic                       err_ovf
);

  localparam int BITDEF = (MAXDEFER > 0) ? $clog2(MAXDEFER + 1) : 1;
  localparam logic [BITRBNK-1:0] LASTB = BITRBNK'(NUMRBNK - 1);
  localparam logic [BITCRED-1:0] CMAX  = BITCRED'(MAXCRED);
  localparam logic [BITDEF-1:0]  DMAX  = BITDEF'(MAXDEFER);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_PEND, ST_STALL} state_t;

  state_t               state_q, state_d;
  logic [BITRBNK-1:0]   ptr_q, ptr_d;
  logic [BITDEF-1:0]    defer_q, defer_d;
  logic [BITCRED-1:0]   cred_q, cred_d;
  logic                 tog_q, tog_d;
  logic                 ovf_q, ovf_d;
  logic                 ready_q, ready_d;
  logic                 refrb_q, refrb_d;
  logic [BITRBNK-1:0]   bankb_q, bankb_d;
  logic                 stall_q, stall_d;
  logic [BITRBNK-1:0]   sbank_q, sbank_d;

  logic hit, eff, issue, sub;

  always_comb begin
    hit = 1'b0;
    for (int p = 0; p < NUMPT; p++)
      if (acc_vld[p] && (acc_bank[p*BITRBNK +: BITRBNK] == ptr_q)) hit = 1'b1;
  end

  // In half-frequency mode only the second pulse of each pair earns a credit.
  assign eff   = refr & ((REFFRHF == 0) | tog_q);
  assign tog_d = refr ? ~tog_q : tog_q;

  always_comb begin
    state_d = state_q;
    defer_d = defer_q;
    stall_d = 1'b0;
    issue   = 1'b0;
    sub     = 1'b0;
    ready_d = (state_q != ST_INIT);
    case (state_q)
      ST_INIT: begin
        issue = 1'b1;
        if (ptr_q == LASTB) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if ((cred_q != '0) || eff) state_d = ST_PEND;
      end
      ST_PEND: begin
        if (hit) begin
          defer_d = defer_q + 1'b1;
          if (defer_d == DMAX) begin
            state_d = ST_STALL;
            stall_d = 1'b1;
          end
        end else begin
          issue   = 1'b1;
          sub     = 1'b1;
          defer_d = '0;
        end
      end
      ST_STALL: begin
        issue   = 1'b1;
        sub     = 1'b1;
        defer_d = '0;
      end
      default: state_d = ST_INIT;
    endcase

    cred_d = cred_q;
    ovf_d  = ovf_q;
    case ({eff, sub})
      2'b10: begin
        if (cred_q == CMAX) ovf_d = 1'b1;
        else                cred_d = cred_q + 1'b1;
      end
      2'b01:   cred_d = cred_q - 1'b1;
      default: cred_d = cred_q;
    endcase

    // After a credited issue, stay pending only while credit remains.
    if (sub) state_d = (cred_d != '0) ? ST_PEND : ST_IDLE;

    ptr_d   = issue ? ((ptr_q == LASTB) ? '0 : ptr_q + 1'b1) : ptr_q;
    refrb_d = issue;
    bankb_d = issue ? ptr_q : '0;
    sbank_d = stall_d ? ptr_q : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
      defer_q <= '0;
      cred_q  <= '0;
      tog_q   <= 1'b0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b0;
      refrb_q <= 1'b0;
      bankb_q <= '0;
      stall_q <= 1'b0;
      sbank_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      defer_q <= defer_d;
      cred_q  <= cred_d;
      tog_q   <= tog_d;
      ovf_q   <= ovf_d;
      ready_q <= ready_d;
      refrb_q <= refrb_d;
      bankb_q <= bankb_d;
      stall_q <= stall_d;
      sbank_q <= sbank_d;
    end
  end

  assign ready      = ready_q;
  assign refrB      = refrb_q;
  assign bankB      = bankb_q;
  assign stall      = stall_q;
  assign stall_bank = sbank_q;
  assign cred       = cred_q;
  assign err_ovf    = ovf_q;

  // Upstream must keep off the reserved bank while the forced refresh is decided.
  a_no_hit_in_stall: assert property (@(posedge clk) disable iff (rst)
    (state_q == ST_STALL) |-> !hit);
  a_refr_stall_excl: assert property (@(posedge clk) disable iff (rst)
    !(refrb_q && stall_q));

endmodule

// File: tb/tb_algo_mrw_refr_sched.sv
// Bench for algo_mrw_refr_sched: two instances (4 banks full-rate, 3 banks half-rate)
// checked every cycle against a credit/pointer model plus hand-computed expectations.
module tb_algo_mrw_refr_sched;
  localparam int MAXC = 7;
  localparam int MAXD = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       refr0, refr1;
  logic [1:0] vld0, vld1;
  logic [3:0] bnk0, bnk1;
  logic       ready0, refrB0, stall0, err0;
  logic       ready1, refrB1, stall1, err1;
  logic [1:0] bankB0, sbank0, bankB1, sbank1;
  logic [2:0] cred0, cred1;

  algo_mrw_refr_sched u0 (
    .clk(clk), .rst(rst), .refr(refr0), .acc_vld(vld0), .acc_bank(bnk0),
    .ready(ready0), .refrB(refrB0), .bankB(bankB0), .stall(stall0),
    .stall_bank(sbank0), .cred(cred0), .err_ovf(err0));

  algo_mrw_refr_sched #(.NUMRBNK(3), .BITRBNK(2), .REFFRHF(1)) u1 (
    .clk(clk), .rst(rst), .refr(refr1), .acc_vld(vld1), .acc_bank(bnk1),
    .ready(ready1), .refrB(refrB1), .bankB(bankB1), .stall(stall1),
    .stall_bank(sbank1), .cred(cred1), .err_ovf(err1));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: banked credits, a rotating bank pointer, and a count of cycles refused by conflicts.
  int m_nb[2], m_init[2], m_cred[2], m_ptr[2], m_def[2];
  bit m_hf[2], m_tog[2], m_post[2], m_spend[2], m_err[2], m_rdy[2];
  bit e_refr[2], e_stall[2];
  int e_bank[2], e_sbank[2];

  task automatic mreset();
    m_nb[0] = 4; m_nb[1] = 3;
    m_hf[0] = 1'b0; m_hf[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      m_init[i] = m_nb[i]; m_cred[i] = 0; m_ptr[i] = 0; m_def[i] = 0;
      m_tog[i] = 0; m_post[i] = 0; m_spend[i] = 0; m_err[i] = 0; m_rdy[i] = 0;
      e_refr[i] = 0; e_stall[i] = 0; e_bank[i] = 0; e_sbank[i] = 0;
    end
  endtask

  task automatic missue(input int i);
    e_refr[i] = 1'b1;
    e_bank[i] = m_ptr[i];
    m_ptr[i]  = (m_ptr[i] + 1) % m_nb[i];
  endtask

  task automatic mstep(input int i, input logic r, input logic [1:0] v, input logic [3:0] b);
    bit add, hit;
    int sub, c;
    add = r && (!m_hf[i] || m_tog[i]);
    if (r) m_tog[i] = !m_tog[i];
    hit = (v[0] && int'(b[1:0]) == m_ptr[i]) || (v[1] && int'(b[3:2]) == m_ptr[i]);
    e_refr[i] = 0; e_stall[i] = 0; sub = 0;
    m_rdy[i] = (m_init[i] == 0);
    if (m_init[i] > 0) begin
      missue(i);
      m_init[i]--;
      m_post[i] = (m_init[i] == 0);
    end else if (m_post[i]) begin
      m_post[i] = 0;
    end else if (m_spend[i]) begin
      missue(i); sub = 1; m_spend[i] = 0; m_def[i] = 0;
    end else if (m_cred[i] > 0) begin
      if (hit) begin
        m_def[i]++;
        if (m_def[i] == MAXD) begin
          e_stall[i] = 1; e_sbank[i] = m_ptr[i]; m_spend[i] = 1;
        end
      end else begin
        missue(i); sub = 1; m_def[i] = 0;
      end
    end
    c = m_cred[i] + (add ? 1 : 0) - sub;
    if (c > MAXC) begin c = MAXC; m_err[i] = 1; end
    m_cred[i] = c;
  endtask

  initial begin
    mreset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) mreset();
      else begin
        mstep(0, refr0, vld0, bnk0);
        mstep(1, refr1, vld1, bnk1);
      end
    end
  end

  task automatic cmp(input int i, input logic rb, input logic [1:0] bb, input logic st,
                     input logic [1:0] sb, input logic [2:0] cr, input logic er, input logic rd);
    chk($sformatf("u%0d refrB", i), rb, e_refr[i]);
    if (e_refr[i]) chk($sformatf("u%0d bankB", i), bb, e_bank[i]);
    chk($sformatf("u%0d stall", i), st, e_stall[i]);
    if (e_stall[i]) chk($sformatf("u%0d stall_bank", i), sb, e_sbank[i]);
    chk($sformatf("u%0d cred", i), cr, m_cred[i]);
    chk($sformatf("u%0d err_ovf", i), er, m_err[i]);
    chk($sformatf("u%0d ready", i), rd, m_rdy[i]);
  endtask

  int q1[$];
  initial begin
    forever begin
      @(negedge clk);
      cmp(0, refrB0, bankB0, stall0, sbank0, cred0, err0, ready0);
      cmp(1, refrB1, bankB1, stall1, sbank1, cred1, err1, ready1);
      if (!rst && refrB1 && ready1) q1.push_back(int'(bankB1));
    end
  end

  int cyc;
  int exp_seq[7] = '{0, 1, 2, 0, 1, 2, 0};

  initial begin
    rst = 1'b1;
    refr0 = 0; refr1 = 0; vld0 = 0; vld1 = 0; bnk0 = 0; bnk1 = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    while (cyc < 74) begin
      refr0 = (cyc == 8) || (cyc == 12) || (cyc == 16) || (cyc == 24) ||
              (cyc >= 32 && cyc < 56) || (cyc == 72) || (cyc == 73);
      refr1 = (cyc < 4) || (cyc >= 40 && cyc < 50);
      if (cyc >= 16 && cyc < 21) begin
        vld0 = stall0 ? 2'b00 : 2'b01; bnk0 = 4'b0010;
      end else if (cyc >= 24 && cyc < 28) begin
        vld0 = 2'b11; bnk0 = (cyc == 27) ? {2'd1, 2'd0} : {2'd3, 2'd0};
      end else if (cyc >= 32 && cyc < 56) begin
        vld0 = stall0 ? 2'b00 : 2'b01; bnk0 = {2'b00, m_ptr[0][1:0]};
      end else begin
        vld0 = 2'b00; bnk0 = 4'b0000;
      end

      if (cyc >= 1 && cyc <= 4) begin
        chk("init refrB", refrB0, 1);
        chk("init bankB", bankB0, cyc - 1);
      end
      if (cyc >= 1 && cyc <= 5) chk("init stall", stall0, 0);
      if (cyc == 4) begin
        chk("ready early", ready0, 0);
        chk("half-rate cred", cred1, 2);
      end
      if (cyc == 5) begin
        chk("ready rise", ready0, 1);
        chk("init end refrB", refrB0, 0);
      end
      if (cyc == 9) chk("latency early", refrB0, 0);
      if (cyc == 10) begin
        chk("latency2 refrB", refrB0, 1);
        chk("latency2 bankB", bankB0, 0);
        chk("cred drained", cred0, 0);
      end
      if (cyc == 13) chk("second early", refrB0, 0);
      if (cyc == 14) begin
        chk("second refrB", refrB0, 1);
        chk("second bankB", bankB0, 1);
      end
      if (cyc >= 17 && cyc <= 20) chk("deferred refrB", refrB0, 0);
      if (cyc >= 17 && cyc <= 19) chk("deferred stall", stall0, 0);
      if (cyc == 20) begin
        chk("force stall", stall0, 1);
        chk("force stall_bank", sbank0, 2);
      end
      if (cyc == 21) begin
        chk("force refrB", refrB0, 1);
        chk("force bankB", bankB0, 2);
        chk("force stall off", stall0, 0);
      end
      if (cyc >= 25 && cyc <= 27) chk("port1 defer refrB", refrB0, 0);
      if (cyc >= 25 && cyc <= 28) chk("port1 no stall", stall0, 0);
      if (cyc == 28) begin
        chk("port1 clear refrB", refrB0, 1);
        chk("port1 clear bankB", bankB0, 3);
      end
      if (cyc == 56) begin
        chk("saturated cred", cred0, 7);
        chk("overflow set", err0, 1);
      end
      if (cyc == 70) begin
        chk("drained cred", cred0, 0);
        chk("overflow sticky", err0, 1);
        chk("wrap count", q1.size(), 7);
        for (int k = 0; k < 7; k++)
          if (k < q1.size()) chk($sformatf("wrap seq %0d", k), q1[k], exp_seq[k]);
      end
      @(negedge clk);
      cyc++;
    end

    refr0 = 0; vld0 = 0; bnk0 = 0;
    #2 rst = 1'b1;
    #1;
    chk("mid rst refrB", refrB0, 0);
    chk("mid rst ready", ready0, 0);
    chk("mid rst cred", cred0, 0);
    chk("mid rst err", err0, 0);
    chk("mid rst stall", stall0, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("reinit refrB", refrB0, 1);
    chk("reinit bankB", bankB0, 0);
    chk("reinit ready", ready0, 0);
    @(negedge clk);
    chk("reinit bankB1", bankB0, 1);
    repeat (6) @(negedge clk);
    chk("reinit ready rise", ready0, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
